axis_pktgen_chk: RTL and testbench
==================================

Name: axis_pktgen_chk

Overview:
Parametrised AXI-Stream packet generator and checker used as a synthesizable loopback and stimulus block on the adapter boards. Generates packets with a deterministic byte pattern on a master stream. Verifies the same pattern on a slave stream, either looped back through the DUT path or wired directly. Generalises the fixed-width, tie-off style board bench into a run-time configurable traffic source and sink with error accounting.

Parameters:
C_DATA_WIDTH, 64, stream data width in bits; must be 64, 128 or 256
KEEP_WIDTH, C_DATA_WIDTH/8, bytes per beat
LEN_WIDTH, 16, width of the packet-length field in bytes
CNT_WIDTH, 32, width of the packet and error counters

Ports:
clk  in  1  block clock; all logic is on the rising edge
rst  in  1  reset, asynchronous, active-high
start  in  1  one-cycle pulse; begins a run; ignored while busy=1
stop  in  1  one-cycle pulse; ends the run after the current packet's tlast is accepted
cfg_len  in  LEN_WIDTH  packet length in bytes; sampled at start; 0 is treated as 1
cfg_count  in  CNT_WIDTH  packets per run; sampled at start; 0 means run until stop
cfg_gap  in  8  idle cycles inserted after each accepted tlast; sampled at start
m_axis_tdata  out  C_DATA_WIDTH  generated data
m_axis_tkeep  out  KEEP_WIDTH  byte enables; contiguous from bit 0
m_axis_tlast  out  1  last beat of a packet
m_axis_tvalid  out  1  beat valid
m_axis_tready  in  1  sink ready
s_axis_tdata  in  C_DATA_WIDTH  data under check
s_axis_tkeep  in  KEEP_WIDTH  byte enables under check
s_axis_tlast  in  1  last beat under check
s_axis_tvalid  in  1  beat valid
s_axis_tready  out  1  tied high whenever not in reset
busy  out  1  generator active
done  out  1  one-cycle pulse when a run completes
tx_pkts  out  CNT_WIDTH  packets sent in the current run
rx_pkts  out  CNT_WIDTH  packets received since start
err_cnt  out  CNT_WIDTH  erroneous beats; saturates at all-ones
first_err_pkt  out  CNT_WIDTH  rx packet index of the first error; all-ones if no error

Behaviour:
- Reset: all outputs are 0, except first_err_pkt, which is all-ones. Generator state is IDLE. Reset asserted mid-packet drops tvalid immediately and discards the partial packet.
- Pattern: byte i of packet n = (n + i) mod 256, with n counted from 0 at start. Byte 0 is in tdata[7:0].
- Beats per packet = ceil(len/KEEP_WIDTH). tkeep is all-ones on every beat except the last. Last-beat tkeep has ((len-1) mod KEEP_WIDTH)+1 low bits set. Bytes outside tkeep are driven 0.
- Generator FSM:
  - IDLE to SEND on start. tvalid rises the cycle after start; tx_pkts, rx_pkts, err_cnt and first_err_pkt are cleared on that same start edge.
  - SEND: a beat advances only on tvalid & tready. tdata, tkeep and tlast are held stable while tvalid=1 and tready=0.
  - On an accepted tlast: tx_pkts is incremented. Next state is DONE if tx_pkts reaches cfg_count (nonzero) or a stop is pending; otherwise GAP if cfg_gap>0; otherwise SEND with no bubble.
  - GAP: tvalid=0 for exactly cfg_gap cycles, then SEND.
  - DONE: done is pulsed for one cycle, then IDLE. busy=1 in SEND and GAP.
- stop is latched as pending. A stop received in GAP goes to DONE at once. A stop received in IDLE is ignored. start and stop in the same cycle while IDLE: start is taken and stop is ignored.
- start while busy is ignored, and configuration does not change mid-run.
- Checker (runs whenever s_axis_tvalid=1):
  - Tracks the expected packet index and byte offset, and uses the length latched at start.
  - A beat is erroneous if any kept byte mismatches, if tkeep differs from the expected value, or if tlast differs from the expected value.
  - Each erroneous beat increments err_cnt by 1, regardless of how many faults the beat contains.
  - On a received tlast (expected or not), rx_pkts is incremented and the checker resyncs to offset 0 of the next packet index.
  - first_err_pkt is written only while it is all-ones.
  - Counters wrap except err_cnt.

Decomposition:
- Package axis_pktgen_pkg holds:
  - the gen_state_t enum (IDLE, SEND, GAP, DONE)
  - function pattern_beat(pkt, offset), returning the expected tdata
  - function last_keep(len), returning the expected last-beat tkeep
- One sub-module, axis_pkt_checker, contains the receive side and its counters, sharing the package functions.

Test Plan:
- Width 64, len=20, count=3, gap=2, tready=1, loopback: 3 beats per packet, last tkeep=0x0F, 2 idle cycles between packets; tx_pkts=3, rx_pkts=3, err_cnt=0, done pulses once.
- len=8, count=4, tready toggling 1/0 every cycle: each beat is held stable across stall cycles, packet 2 beat 0 tdata=0x0908070605040302, err_cnt=0.
- Loopback with packet 1 byte 3 flipped: err_cnt=1, first_err_pkt=1, rx_pkts=count.
- count=0, gap=0, stop after 5 tlasts: run ends after the 5th or 6th accepted tlast (whichever is in flight), then done, busy=0.
- rst asserted mid-beat of packet 2: tvalid=0 the same cycle, all counters 0, first_err_pkt all-ones. A new start after reset produces packet 0 byte 0 = 0x00.
- len=0 and len=9 at width 128: len=0 gives 1 beat with tkeep=0x0001; len=9 gives 1 beat with tkeep=0x01FF.

Source files
------------

// File: rtl/axis_pktgen_pkg.sv
// Shared types and byte-pattern helpers for the AXI-Stream packet generator/checker.
// Pattern rule: byte i of packet n carries (n + i) mod 256.
package axis_pktgen_pkg;

  typedef enum logic [1:0] {IDLE, SEND, GAP, DONE} gen_state_t;

  localparam int MAX_DW = 256;
  localparam int MAX_KW = MAX_DW / 8;

  // Full-width beat pattern; callers narrow it to their data width.
  function automatic logic [MAX_DW-1:0] pattern_beat(input logic [7:0] pkt,
                                                     input logic [7:0] offset);
    logic [MAX_DW-1:0] d;
    d = '0;
    for (int j = 0; j < MAX_KW; j++) begin
      d[8*j +: 8] = pkt + offset + 8'(j);
    end
    return d;
  endfunction

  // len must already be at least 1.
  function automatic logic [MAX_KW-1:0] last_keep(input logic [31:0] len, input int kw);
    logic [MAX_KW-1:0] k;
    logic [31:0]       n;
    n = ((len - 32'd1) % 32'(kw)) + 32'd1;
    k = '0;
    for (int j = 0; j < MAX_KW; j++) begin
      if (32'(j) < n) k[j] = 1'b1;
    end
    return k;
  endfunction

endpackage

// File: rtl/axis_pktgen_chk_checker.sv
// Receive side: checks incoming beats against the expected pattern and keeps
// the rx packet count, saturating error count and first-error packet index.
module axis_pkt_checker
  import axis_pktgen_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clear,
  input  logic [LEN_WIDTH-1:0]    len,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic [CNT_WIDTH-1:0]    rx_pkts,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic [CNT_WIDTH-1:0]    first_err_pkt
);

  localparam logic [LEN_WIDTH:0]   KW_EXT  = (LEN_WIDTH+1)'(KEEP_WIDTH);
  localparam logic [LEN_WIDTH-1:0] KW_STEP = LEN_WIDTH'(KEEP_WIDTH);

  logic [CNT_WIDTH-1:0]    rx_pkts_q, rx_pkts_d;
  logic [CNT_WIDTH-1:0]    err_cnt_q, err_cnt_d;
  logic [CNT_WIDTH-1:0]    first_err_q, first_err_d;
  logic [LEN_WIDTH-1:0]    off_q, off_d;

  logic                    exp_last;
  logic [KEEP_WIDTH-1:0]   exp_keep;
  logic [C_DATA_WIDTH-1:0] exp_data;
  logic [C_DATA_WIDTH-1:0] rx_mask;
  logic                    beat_err;

  // Expected packet index is simply the number of packets already received.
  assign exp_last = ({1'b0, off_q} + KW_EXT) >= {1'b0, len};
  assign exp_keep = exp_last ? KEEP_WIDTH'(last_keep(32'(len), KEEP_WIDTH)) : '1;
  assign exp_data = C_DATA_WIDTH'(pattern_beat(rx_pkts_q[7:0], off_q[7:0]));

  always_comb begin
    rx_mask = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      rx_mask[8*j +: 8] = {8{s_axis_tkeep[j]}};
    end
  end

  assign beat_err = (((s_axis_tdata ^ exp_data) & rx_mask) != '0) ||
                    (s_axis_tkeep != exp_keep) || (s_axis_tlast != exp_last);

  always_comb begin
    rx_pkts_d   = rx_pkts_q;
    err_cnt_d   = err_cnt_q;
    first_err_d = first_err_q;
    off_d       = off_q;
    if (clear) begin
      rx_pkts_d   = '0;
      err_cnt_d   = '0;
      first_err_d = '1;
      off_d       = '0;
    end else if (s_axis_tvalid) begin
      if (beat_err) begin
        if (err_cnt_q != '1) err_cnt_d = err_cnt_q + CNT_WIDTH'(1);
        if (first_err_q == '1) first_err_d = rx_pkts_q;
      end
      // Any tlast resyncs the checker onto the next packet.
      if (s_axis_tlast) begin
        rx_pkts_d = rx_pkts_q + CNT_WIDTH'(1);
        off_d     = '0;
      end else begin
        off_d = off_q + KW_STEP;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_pkts_q   <= '0;
      err_cnt_q   <= '0;
      first_err_q <= '1;
      off_q       <= '0;
    end else begin
      rx_pkts_q   <= rx_pkts_d;
      err_cnt_q   <= err_cnt_d;
      first_err_q <= first_err_d;
      off_q       <= off_d;
    end
  end

  assign rx_pkts       = rx_pkts_q;
  assign err_cnt       = err_cnt_q;
  assign first_err_pkt = first_err_q;

endmodule

// File: rtl/axis_pktgen_chk.sv
// Run-time configurable AXI-Stream pattern generator with a matching checker,
// used as a loopback traffic source/sink on the adapter boards.
module axis_pktgen_chk
  import axis_pktgen_pkg::*;
#(
  parameter int C_DATA_WIDTH = 64,
  parameter int KEEP_WIDTH   = C_DATA_WIDTH / 8,
  parameter int LEN_WIDTH    = 16,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic                    stop,
  input  logic [LEN_WIDTH-1:0]    cfg_len,
  input  logic [CNT_WIDTH-1:0]    cfg_count,
  input  logic [7:0]              cfg_gap,
  output logic [C_DATA_WIDTH-1:0] m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]   m_axis_tkeep,
  output logic                    m_axis_tlast,
  output logic                    m_axis_tvalid,
  input  logic                    m_axis_tready,
  input  logic [C_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0]   s_axis_tkeep,
  input  logic                    s_axis_tlast,
  input  logic                    s_axis_tvalid,
  output logic                    s_axis_tready,
  output logic                    busy,
  output logic                    done,
  output logic [CNT_WIDTH-1:0]    tx_pkts,
  output logic [CNT_WIDTH-1:0]    rx_pkts,
  output logic [CNT_WIDTH-1:0]    err_cnt,
  output logic [CNT_WIDTH-1:0]    first_err_pkt
);

  localparam logic [LEN_WIDTH:0]   KW_EXT  = (LEN_WIDTH+1)'(KEEP_WIDTH);
  localparam logic [LEN_WIDTH-1:0] KW_STEP = LEN_WIDTH'(KEEP_WIDTH);

  gen_state_t              state_q, state_d;
  logic [LEN_WIDTH-1:0]    len_q, len_d;
  logic [CNT_WIDTH-1:0]    count_q, count_d;
  logic [CNT_WIDTH-1:0]    tx_pkts_q, tx_pkts_d;
  logic [7:0]              gap_q, gap_d;
  logic [7:0]              gap_cnt_q, gap_cnt_d;
  logic [LEN_WIDTH-1:0]    off_q, off_d;
  logic                    stop_pend_q, stop_pend_d;

  logic                    start_acc;
  logic                    beat_last;
  logic [KEEP_WIDTH-1:0]   beat_keep;
  logic [C_DATA_WIDTH-1:0] beat_data;
  logic [C_DATA_WIDTH-1:0] byte_mask;

  assign start_acc = start && (state_q == IDLE);

  // Packet index is the number of packets already sent in this run.
  assign beat_last = ({1'b0, off_q} + KW_EXT) >= {1'b0, len_q};
  assign beat_keep = beat_last ? KEEP_WIDTH'(last_keep(32'(len_q), KEEP_WIDTH)) : '1;
  assign beat_data = C_DATA_WIDTH'(pattern_beat(tx_pkts_q[7:0], off_q[7:0]));

  always_comb begin
    byte_mask = '0;
    for (int j = 0; j < KEEP_WIDTH; j++) begin
      byte_mask[8*j +: 8] = {8{beat_keep[j]}};
    end
  end

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    count_d     = count_q;
    tx_pkts_d   = tx_pkts_q;
    gap_d       = gap_q;
    gap_cnt_d   = gap_cnt_q;
    off_d       = off_q;
    stop_pend_d = stop_pend_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = SEND;
          len_d       = (cfg_len == '0) ? LEN_WIDTH'(1) : cfg_len;
          count_d     = cfg_count;
          gap_d       = cfg_gap;
          tx_pkts_d   = '0;
          off_d       = '0;
          stop_pend_d = 1'b0;
        end
      end
      SEND: begin
        if (stop) stop_pend_d = 1'b1;
        if (m_axis_tready) begin
          if (beat_last) begin
            off_d     = '0;
            tx_pkts_d = tx_pkts_q + CNT_WIDTH'(1);
            if (((count_q != '0) && (tx_pkts_d == count_q)) || stop_pend_q || stop) begin
              state_d = DONE;
            end else if (gap_q != 8'd0) begin
              state_d   = GAP;
              gap_cnt_d = gap_q;
            end
          end else begin
            off_d = off_q + KW_STEP;
          end
        end
      end
      GAP: begin
        if (stop || stop_pend_q) begin
          state_d = DONE;
        end else if (gap_cnt_q == 8'd1) begin
          state_d = SEND;
        end else begin
          gap_cnt_d = gap_cnt_q - 8'd1;
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      len_q       <= LEN_WIDTH'(1);
      count_q     <= '0;
      tx_pkts_q   <= '0;
      gap_q       <= '0;
      gap_cnt_q   <= '0;
      off_q       <= '0;
      stop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      count_q     <= count_d;
      tx_pkts_q   <= tx_pkts_d;
      gap_q       <= gap_d;
      gap_cnt_q   <= gap_cnt_d;
      off_q       <= off_d;
      stop_pend_q <= stop_pend_d;
    end
  end

  assign m_axis_tvalid = (state_q == SEND);
  assign m_axis_tdata  = m_axis_tvalid ? (beat_data & byte_mask) : '0;
  assign m_axis_tkeep  = m_axis_tvalid ? beat_keep : '0;
  assign m_axis_tlast  = m_axis_tvalid && beat_last;
  assign busy          = (state_q == SEND) || (state_q == GAP);
  assign done          = (state_q == DONE);
  assign tx_pkts       = tx_pkts_q;
  assign s_axis_tready = ~rst;

  axis_pkt_checker #(
    .C_DATA_WIDTH(C_DATA_WIDTH),
    .KEEP_WIDTH  (KEEP_WIDTH),
    .LEN_WIDTH   (LEN_WIDTH),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_checker (
    .clk          (clk),
    .rst          (rst),
    .clear        (start_acc),
    .len          (len_q),
    .s_axis_tdata (s_axis_tdata),
    .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tlast (s_axis_tlast),
    .s_axis_tvalid(s_axis_tvalid),
    .rx_pkts      (rx_pkts),
    .err_cnt      (err_cnt),
    .first_err_pkt(first_err_pkt)
  );

endmodule

// File: tb/tb_axis_pktgen_chk.sv
// Bench for axis_pktgen_chk: a 64-bit instance in loopback (with optional byte
// corruption) is tracked cycle by cycle against a byte-level packet model; a
// 128-bit instance shares the stimulus and has its first beat checked.
module tb_axis_pktgen_chk;

  localparam int DW  = 64;
  localparam int KW  = 8;
  localparam int DWB = 128;
  localparam int KWB = 16;
  localparam int LW  = 16;
  localparam int CW  = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          start, start_b, stop, tready;
  logic [LW-1:0] cfg_len;
  logic [CW-1:0] cfg_count;
  logic [7:0]    cfg_gap;

  logic [DW-1:0] a_tdata, a_s_tdata, corrupt_mask;
  logic [KW-1:0] a_tkeep;
  logic          a_tlast, a_tvalid, a_s_tvalid, a_s_tready, a_busy, a_done, corrupt;
  logic [CW-1:0] a_tx, a_rx, a_err, a_first;

  logic [DWB-1:0] b_tdata;
  logic [KWB-1:0] b_tkeep;
  logic           b_tlast, b_tvalid, b_s_tvalid, b_s_tready, b_busy, b_done;
  logic [CW-1:0]  b_tx, b_rx, b_err, b_first;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  // Loopback: only accepted beats reach the checker; one byte may be flipped.
  assign a_s_tdata  = a_tdata ^ (corrupt ? corrupt_mask : '0);
  assign a_s_tvalid = a_tvalid & tready;
  assign b_s_tvalid = b_tvalid & tready;

  axis_pktgen_chk #(.C_DATA_WIDTH(DW)) dut_a (
    .clk(clk), .rst(rst), .start(start), .stop(stop),
    .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
    .m_axis_tdata(a_tdata), .m_axis_tkeep(a_tkeep), .m_axis_tlast(a_tlast),
    .m_axis_tvalid(a_tvalid), .m_axis_tready(tready),
    .s_axis_tdata(a_s_tdata), .s_axis_tkeep(a_tkeep), .s_axis_tlast(a_tlast),
    .s_axis_tvalid(a_s_tvalid), .s_axis_tready(a_s_tready),
    .busy(a_busy), .done(a_done), .tx_pkts(a_tx), .rx_pkts(a_rx),
    .err_cnt(a_err), .first_err_pkt(a_first)
  );

  axis_pktgen_chk #(.C_DATA_WIDTH(DWB)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .stop(stop),
    .cfg_len(cfg_len), .cfg_count(cfg_count), .cfg_gap(cfg_gap),
    .m_axis_tdata(b_tdata), .m_axis_tkeep(b_tkeep), .m_axis_tlast(b_tlast),
    .m_axis_tvalid(b_tvalid), .m_axis_tready(tready),
    .s_axis_tdata(b_tdata), .s_axis_tkeep(b_tkeep), .s_axis_tlast(b_tlast),
    .s_axis_tvalid(b_s_tvalid), .s_axis_tready(b_s_tready),
    .busy(b_busy), .done(b_done), .tx_pkts(b_tx), .rx_pkts(b_rx),
    .err_cnt(b_err), .first_err_pkt(b_first)
  );

  task automatic checkOutput(input string tag, input logic [255:0] obsv, input logic [255:0] reqd);
    n_checks++;
    assert (obsv === reqd) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obsv, reqd);
    end
  endtask

  // Beat `beat` of packet `pkt`: byte i of the packet is (pkt + i) mod 256.
  function automatic void modelBeat(input int pkt, input int beat, input int leff, input int kw,
                                    output logic [255:0] data, output logic [31:0] keep,
                                    output logic last);
    int i;
    data = '0;
    keep = '0;
    for (int j = 0; j < kw; j++) begin
      i = beat * kw + j;
      if (i < leff) begin
        data[8*j +: 8] = 8'((pkt + i) % 256);
        keep[j] = 1'b1;
      end
    end
    last = ((beat + 1) * kw) >= leff;
  endfunction

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_a_tdata"}, a_tdata, 0);
    checkOutput({tag, "_a_tkeep"}, a_tkeep, 0);
    checkOutput({tag, "_a_tvalid"}, a_tvalid, 0);
    checkOutput({tag, "_a_tlast"}, a_tlast, 0);
    checkOutput({tag, "_a_busy"}, a_busy, 0);
    checkOutput({tag, "_a_done"}, a_done, 0);
    checkOutput({tag, "_a_tx"}, a_tx, 0);
    checkOutput({tag, "_a_rx"}, a_rx, 0);
    checkOutput({tag, "_a_err"}, a_err, 0);
    checkOutput({tag, "_a_first"}, a_first, 32'hFFFF_FFFF);
    checkOutput({tag, "_a_stready"}, a_s_tready, 0);
    checkOutput({tag, "_b_tdata"}, b_tdata, 0);
    checkOutput({tag, "_b_tkeep"}, b_tkeep, 0);
    checkOutput({tag, "_b_tvalid"}, b_tvalid, 0);
    checkOutput({tag, "_b_tlast"}, b_tlast, 0);
    checkOutput({tag, "_b_busy"}, b_busy, 0);
    checkOutput({tag, "_b_done"}, b_done, 0);
    checkOutput({tag, "_b_tx"}, b_tx, 0);
    checkOutput({tag, "_b_rx"}, b_rx, 0);
    checkOutput({tag, "_b_err"}, b_err, 0);
    checkOutput({tag, "_b_first"}, b_first, 32'hFFFF_FFFF);
    checkOutput({tag, "_b_stready"}, b_s_tready, 0);
  endtask

  // One run: ready_mode 0=always, 1=toggle, 2=random; flip_pkt<0 disables corruption;
  // stop_after>0 pulses stop once that many packets have been accepted.
  task automatic applyStimulus(input int len, input int count, input int gap, input int ready_mode,
                               input int flip_pkt, input int flip_byte, input int stop_after);
    int leff, pkt, beat, sent, gap_left, cycles, n_err;
    bit ended, stop_pend;
    logic [31:0]  exp_first;
    logic [255:0] md;
    logic [31:0]  mk;
    logic         ml;
    leff = (len == 0) ? 1 : len;
    pkt = 0; beat = 0; sent = 0; gap_left = 0; cycles = 0; n_err = 0;
    ended = 0; stop_pend = 0; exp_first = 32'hFFFF_FFFF;
    @(negedge clk);
    cfg_len = LW'(len); cfg_count = CW'(count); cfg_gap = 8'(gap);
    start = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start = 1'b0; start_b = 1'b0;
    checkOutput("start_tx_clr", a_tx, 0);
    checkOutput("start_rx_clr", a_rx, 0);
    checkOutput("start_err_clr", a_err, 0);
    checkOutput("start_first_clr", a_first, 32'hFFFF_FFFF);
    modelBeat(0, 0, leff, KWB, md, mk, ml);
    checkOutput("b_first_tvalid", b_tvalid, 1);
    checkOutput("b_first_tdata", b_tdata, md[DWB-1:0]);
    checkOutput("b_first_tkeep", b_tkeep, mk[KWB-1:0]);
    checkOutput("b_first_tlast", b_tlast, ml);
    while (!ended && cycles < 4000) begin
      checkOutput("busy", a_busy, 1);
      checkOutput("done_low", a_done, 0);
      checkOutput("tx_pkts", a_tx, sent);
      checkOutput("rx_pkts", a_rx, sent);
      checkOutput("err_cnt", a_err, n_err);
      stop = 1'b0; start = 1'b0; corrupt = 1'b0;
      if (stop_after > 0 && sent >= stop_after && !stop_pend) begin
        stop = 1'b1; stop_pend = 1;
      end
      if (cycles == 2) begin
        start = 1'b1;
        cfg_len = LW'($urandom); cfg_count = CW'($urandom_range(1, 3)); cfg_gap = 8'($urandom);
      end
      if (ready_mode == 0) tready = 1'b1;
      else if (ready_mode == 1) tready = (cycles % 2 == 0);
      else tready = 1'($urandom);
      if (gap_left > 0) begin
        checkOutput("gap_tvalid", a_tvalid, 0);
        if (stop_pend) ended = 1;
        else gap_left--;
      end else begin
        modelBeat(pkt, beat, leff, KW, md, mk, ml);
        checkOutput("tvalid", a_tvalid, 1);
        checkOutput("tdata", a_tdata, md[DW-1:0]);
        checkOutput("tkeep", a_tkeep, mk[KW-1:0]);
        checkOutput("tlast", a_tlast, ml);
        if (len == 8 && pkt == 2 && beat == 0)
          checkOutput("pkt2_beat0", a_tdata, 64'h0908070605040302);
        if (tready) begin
          if (pkt == flip_pkt && beat == flip_byte / KW) begin
            corrupt = 1'b1;
            corrupt_mask = 64'hFF << (8 * (flip_byte % KW));
            n_err++;
            exp_first = 32'(flip_pkt);
          end
          if (ml) begin
            sent++; pkt++; beat = 0;
            if ((count != 0 && sent == count) || stop_pend) ended = 1;
            else gap_left = gap;
          end else begin
            beat++;
          end
        end
      end
      cycles++;
      @(negedge clk);
    end
    stop = 1'b0; start = 1'b0; corrupt = 1'b0;
    checkOutput("run_end", ended, 1);
    checkOutput("done_pulse", a_done, 1);
    checkOutput("done_busy", a_busy, 0);
    checkOutput("done_tvalid", a_tvalid, 0);
    checkOutput("end_tx", a_tx, sent);
    checkOutput("end_rx", a_rx, sent);
    checkOutput("end_err", a_err, n_err);
    checkOutput("end_first", a_first, exp_first);
    if (count != 0) checkOutput("end_tx_count", a_tx, count);
    @(negedge clk);
    checkOutput("done_single", a_done, 0);
    checkOutput("idle_busy", a_busy, 0);
    for (int i = 0; i < 300 && b_busy; i++) @(negedge clk);
    checkOutput("b_idle", b_busy, 0);
    checkOutput("b_err", b_err, 0);
    checkOutput("b_first", b_first, 32'hFFFF_FFFF);
  endtask

  initial begin
    int l, c;
    rst = 1'b1; start = 1'b0; start_b = 1'b0; stop = 1'b0; tready = 1'b0;
    cfg_len = '0; cfg_count = '0; cfg_gap = '0; corrupt = 1'b0; corrupt_mask = '0;
    repeat (2) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);
    checkOutput("stready_up", a_s_tready, 1);
    checkOutput("idle_tvalid", a_tvalid, 0);

    $display("[TB] len=20 count=3 gap=2 tready=1");
    applyStimulus(20, 3, 2, 0, -1, 0, 0);
    $display("[TB] len=8 count=4 toggling tready");
    applyStimulus(8, 4, 0, 1, -1, 0, 0);
    $display("[TB] corrupted byte 3 of packet 1");
    applyStimulus(20, 3, 1, 2, 1, 3, 0);
    $display("[TB] free-running, stop after 5 packets");
    applyStimulus(8, 0, 0, 0, -1, 0, 5);
    $display("[TB] free-running with gap, stop after 2 packets");
    applyStimulus(12, 0, 3, 2, -1, 0, 2);
    $display("[TB] len=0 and len=9");
    applyStimulus(0, 2, 0, 0, -1, 0, 0);
    applyStimulus(9, 2, 1, 0, -1, 0, 0);

    $display("[TB] reset during packet 2");
    @(negedge clk);
    cfg_len = 16'd20; cfg_count = 32'd5; cfg_gap = 8'd1; tready = 1'b1;
    start = 1'b1; start_b = 1'b1;
    @(negedge clk);
    start = 1'b0; start_b = 1'b0;
    for (int i = 0; i < 200 && !(a_tx == 2 && a_tvalid); i++) @(negedge clk);
    checkOutput("reach_pkt2", a_tx, 2);
    #2 rst = 1'b1;
    #1 checkResetState("midrst");
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(8, 1, 0, 0, -1, 0, 0);

    $display("[TB] randomized runs");
    for (int r = 0; r < 5; r++) begin
      l = $urandom_range(1, 40);
      c = $urandom_range(1, 3);
      if (r % 2 == 0)
        applyStimulus(l, c, $urandom_range(0, 3), $urandom_range(0, 2),
                      $urandom_range(0, c - 1), $urandom_range(0, l - 1), 0);
      else
        applyStimulus(l, c, $urandom_range(0, 3), $urandom_range(0, 2), -1, 0, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
